// File: rtl/traffic_pkg.sv
// Shared phase codes and constant-width helpers for the intersection controller.
// No logic; imported by the tick generator and the phase controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_GREEN  = 3'd0,
    PH_YELLOW = 3'd1,
    PH_ALLRED = 3'd2,
    PH_HOLD   = 3'd3,
    PH_FLASH  = 3'd4
  } phase_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// Prescaler: tick is high for the one clk where the count sits at CLK_DIV-1.
// Free-running, no stall input; count restarts at 0 on reset.
module traffic_tick_gen
  import traffic_pkg::*;
#(
  parameter int CLK_DIV = 100000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (clog2(CLK_DIV) > 1) ? clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach signal controller: green/yellow/all-red rotation with demand skip, preemption and flash.
// Phase changes on tick (flash/preempt entry on the next clk); lamps registered one clk behind state decode.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_APPR   = 4,
  parameter int CLK_DIV  = 100000000,
  parameter int GREEN_T  = 5,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  localparam int IDX_W   = (clog2(N_APPR) > 1) ? clog2(N_APPR) : 1,
  localparam int CNT_W   = clog2(max3(GREEN_T, YELLOW_T, ALLRED_T) + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_APPR-1:0] demand,
  input  logic              skip_en,
  input  logic              preempt,
  input  logic [IDX_W-1:0]  preempt_idx,
  input  logic              flash_en,
  output logic [N_APPR-1:0] red,
  output logic [N_APPR-1:0] yellow,
  output logic [N_APPR-1:0] green,
  output logic [IDX_W-1:0]  active_idx,
  output logic [CNT_W-1:0]  remain,
  output logic [2:0]        phase,
  output logic              tick
);

  localparam logic [CNT_W-1:0]  G_LD  = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0]  Y_LD  = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0]  R_LD  = CNT_W'(ALLRED_T);
  localparam logic [N_APPR-1:0] LAMP0 = N_APPR'(1);

  phase_t            ph_q, ph_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              flash_on_q, flash_on_d;
  logic              restart_q, restart_d;
  logic [N_APPR-1:0] red_d, yellow_d, green_d;
  logic              pre_vld;
  logic              rem_last;
  logic              other_demand;
  logic [IDX_W-1:0]  next_idx;

  function automatic logic [N_APPR-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_APPR-1:0] v;
    v = '0;
    for (int k = 0; k < N_APPR; k++) v[k] = (int'(i) == k);
    return v;
  endfunction

  traffic_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign pre_vld      = preempt && (int'(preempt_idx) < N_APPR);
  assign rem_last     = (rem_q <= CNT_W'(1));
  assign other_demand = |(demand & ~onehot(idx_q));

  // Round-robin search starting after the active approach; the active one is considered last.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    found    = 1'b0;
    next_idx = IDX_W'((int'(idx_q) + 1) % N_APPR);
    cand     = '0;
    if (skip_en) begin
      for (int k = 1; k <= N_APPR; k++) begin
        cand = IDX_W'((int'(idx_q) + k) % N_APPR);
        if (!found && demand[cand]) begin
          found    = 1'b1;
          next_idx = cand;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_q       <= PH_GREEN;
      idx_q      <= '0;
      rem_q      <= G_LD;
      flash_on_q <= 1'b0;
      restart_q  <= 1'b0;
      red        <= ~LAMP0;
      yellow     <= '0;
      green      <= LAMP0;
    end else begin
      ph_q       <= ph_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      flash_on_q <= flash_on_d;
      restart_q  <= restart_d;
      red        <= red_d;
      yellow     <= yellow_d;
      green      <= green_d;
    end
  end

  always_comb begin
    ph_d       = ph_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    flash_on_d = flash_on_q;
    restart_d  = restart_q;
    if (flash_en) begin
      if (ph_q != PH_FLASH) begin
        ph_d       = PH_FLASH;
        idx_d      = '0;
        rem_d      = '0;
        flash_on_d = 1'b1;
      end else if (tick) begin
        flash_on_d = ~flash_on_q;
      end
    end else begin
      case (ph_q)
        PH_GREEN: begin
          if (pre_vld && preempt_idx != idx_q) begin
            ph_d  = PH_YELLOW;
            rem_d = Y_LD;
          end else if (pre_vld) begin
            ph_d  = PH_HOLD;
            rem_d = G_LD;
          end else if (tick) begin
            if (!rem_last) begin
              rem_d = rem_q - CNT_W'(1);
            end else if (skip_en && !other_demand) begin
              rem_d = G_LD;
            end else begin
              ph_d  = PH_YELLOW;
              rem_d = Y_LD;
            end
          end
        end
        PH_YELLOW: begin
          if (tick) begin
            if (!rem_last) begin
              rem_d = rem_q - CNT_W'(1);
            end else begin
              ph_d  = PH_ALLRED;
              rem_d = R_LD;
            end
          end
        end
        PH_ALLRED: begin
          if (tick) begin
            if (!rem_last) begin
              rem_d = rem_q - CNT_W'(1);
            end else begin
              restart_d = 1'b0;
              rem_d     = G_LD;
              if (pre_vld) begin
                ph_d  = PH_HOLD;
                idx_d = preempt_idx;
              end else begin
                ph_d  = PH_GREEN;
                idx_d = restart_q ? '0 : next_idx;
              end
            end
          end
        end
        PH_HOLD: begin
          // A retarget clears through yellow/all-red; a release resumes rotation from here.
          if (pre_vld && preempt_idx != idx_q) begin
            ph_d  = PH_YELLOW;
            rem_d = Y_LD;
          end else if (!pre_vld && tick) begin
            ph_d  = PH_GREEN;
            rem_d = G_LD;
          end
        end
        PH_FLASH: begin
          if (tick) begin
            ph_d      = PH_ALLRED;
            rem_d     = R_LD;
            restart_d = 1'b1;
          end
        end
        default: begin
          ph_d  = PH_GREEN;
          idx_d = '0;
          rem_d = G_LD;
        end
      endcase
    end
  end

  always_comb begin
    red_d    = '0;
    yellow_d = '0;
    green_d  = '0;
    case (ph_d)
      PH_GREEN, PH_HOLD: begin
        green_d = onehot(idx_d);
        red_d   = ~green_d;
      end
      PH_YELLOW: begin
        yellow_d = onehot(idx_d);
        red_d    = ~yellow_d;
      end
      PH_FLASH: yellow_d = {N_APPR{flash_on_d}};
      default:  red_d = '1;
    endcase
  end

  assign phase      = ph_q;
  assign active_idx = idx_q;
  assign remain     = rem_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl (CLK_DIV=4, N_APPR=4, GREEN_T=5, YELLOW_T=2, ALLRED_T=1).
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] demand;
  logic       skip_en, preempt, flash_en;
  logic [1:0] preempt_idx;
  logic [3:0] red, yellow, green;
  logic [1:0] active_idx;
  logic [2:0] remain, phase;
  logic       tick;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [2:0] ph;
    logic [1:0] idx;
    logic [2:0] rem;
    logic [3:0] r;
    logic [3:0] y;
    logic [3:0] g;
  } obs_t;

  obs_t sb[$];

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .N_APPR   (4),
    .CLK_DIV  (4),
    .GREEN_T  (5),
    .YELLOW_T (2),
    .ALLRED_T (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .demand      (demand),
    .skip_en     (skip_en),
    .preempt     (preempt),
    .preempt_idx (preempt_idx),
    .flash_en    (flash_en),
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .active_idx  (active_idx),
    .remain      (remain),
    .phase       (phase),
    .tick        (tick)
  );

  // Per-approach lamp exclusivity on every clk; flash only allows yellows.
  always @(negedge clk) begin
    if (mon_en) begin
      logic ok;
      if (phase == 3'd4)
        ok = (red == 4'b0) && (green == 4'b0);
      else
        ok = ((red | yellow | green) == 4'hF) && ((red & yellow) == 4'b0) &&
             ((red & green) == 4'b0) && ((yellow & green) == 4'b0);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL lamp_onehot t=%0t phase=%0d got r=%b y=%b g=%b", $time, phase, red, yellow, green);
      end
    end
  end

  function automatic obs_t mk(input int ph, input int idx, input int rem, input logic [3:0] fy = 4'b0000);
    obs_t o;
    logic [3:0] oh;
    oh    = 4'b0001 << idx;
    o.ph  = 3'(ph);
    o.idx = 2'(idx);
    o.rem = 3'(rem);
    o.r   = '0;
    o.y   = '0;
    o.g   = '0;
    case (ph)
      0, 3: begin o.g = oh; o.r = ~oh; end
      1:    begin o.y = oh; o.r = ~oh; end
      2:    begin o.r = 4'b1111; o.idx = '0; end
      default: begin o.y = fy; o.idx = '0; end
    endcase
    return o;
  endfunction

  // Owner index is not meaningful during all-red or flash, so it is masked.
  function automatic obs_t obs();
    obs_t o;
    o.ph  = phase;
    o.idx = (phase == 3'd2 || phase == 3'd4) ? 2'd0 : active_idx;
    o.rem = remain;
    o.r   = red;
    o.y   = yellow;
    o.g   = green;
    return o;
  endfunction

  task automatic push_cycle(input int a);
    for (int r = 4; r >= 1; r--) sb.push_back(mk(0, a, r));
    sb.push_back(mk(1, a, 2));
    sb.push_back(mk(1, a, 1));
    sb.push_back(mk(2, 0, 1));
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (tick !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL tick_timeout got tick=%b want 1", tick);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; demand = '0; skip_en = 0; preempt = 0; preempt_idx = '0; flash_en = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs() !== mk(0, 0, 5)) begin bad++; $display("FAIL reset_state got %h want %h", obs(), mk(0, 0, 5)); end
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got %b want 0", tick); end
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (tick !== (k == 3)) begin bad++; $display("FAIL prescale edge%0d got %b want %b", k, tick, k == 3); end
    end
  endtask

  task automatic test_rotation();
    obs_t e;
    skip_en = 0; demand = '0;
    for (int a = 0; a < 4; a++) begin
      push_cycle(a);
      sb.push_back(mk(0, (a + 1) % 4, 5));
    end
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin bad++; $display("FAIL rotation left=%0d got %h want %h", sb.size(), obs(), e); end
    end
  endtask

  task automatic test_skip_demand();
    obs_t e;
    skip_en = 1; demand = 4'b1000;
    push_cycle(0);
    sb.push_back(mk(0, 3, 5));
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin bad++; $display("FAIL skip_demand left=%0d got %h want %h", sb.size(), obs(), e); end
    end
  endtask

  task automatic test_skip_idle();
    obs_t e;
    skip_en = 1; demand = '0;
    repeat (2) begin
      for (int r = 4; r >= 1; r--) sb.push_back(mk(0, 3, r));
      sb.push_back(mk(0, 3, 5));
    end
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin bad++; $display("FAIL skip_idle left=%0d got %h want %h", sb.size(), obs(), e); end
    end
    skip_en = 0;
    push_cycle(3);
    sb.push_back(mk(0, 0, 5));
    sb.push_back(mk(0, 0, 4));
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin bad++; $display("FAIL skip_resume left=%0d got %h want %h", sb.size(), obs(), e); end
    end
  endtask

  task automatic test_preempt();
    obs_t e;
    preempt = 1; preempt_idx = 2'd2;
    @(posedge clk);
    #1;
    total++;
    if (obs() !== mk(1, 0, 2)) begin bad++; $display("FAIL preempt_truncate got %h want %h", obs(), mk(1, 0, 2)); end
    sb.push_back(mk(1, 0, 1));
    sb.push_back(mk(2, 0, 1));
    repeat (3) sb.push_back(mk(3, 2, 5));
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin bad++; $display("FAIL preempt_hold left=%0d got %h want %h", sb.size(), obs(), e); end
    end
    preempt = 0;
    sb.push_back(mk(0, 2, 5));
    push_cycle(2);
    sb.push_back(mk(0, 3, 5));
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin bad++; $display("FAIL preempt_release left=%0d got %h want %h", sb.size(), obs(), e); end
    end
  endtask

  task automatic test_flash();
    obs_t e;
    for (int r = 4; r >= 1; r--) sb.push_back(mk(0, 3, r));
    sb.push_back(mk(1, 3, 2));
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin bad++; $display("FAIL flash_lead left=%0d got %h want %h", sb.size(), obs(), e); end
    end
    flash_en = 1;
    @(posedge clk);
    #1;
    total++;
    if (obs() !== mk(4, 0, 0, 4'b1111)) begin bad++; $display("FAIL flash_entry got %h want %h", obs(), mk(4, 0, 0, 4'b1111)); end
    sb.push_back(mk(4, 0, 0, 4'b0000));
    sb.push_back(mk(4, 0, 0, 4'b1111));
    sb.push_back(mk(4, 0, 0, 4'b0000));
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin bad++; $display("FAIL flash_toggle left=%0d got %h want %h", sb.size(), obs(), e); end
    end
    flash_en = 0;
    sb.push_back(mk(2, 0, 1));
    sb.push_back(mk(0, 0, 5));
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin bad++; $display("FAIL flash_exit left=%0d got %h want %h", sb.size(), obs(), e); end
    end
  endtask

  task automatic test_reset_midphase();
    obs_t e;
    push_cycle(0);
    sb.push_back(mk(0, 1, 5));
    push_cycle(1);
    sb.push_back(mk(0, 2, 5));
    for (int r = 4; r >= 1; r--) sb.push_back(mk(0, 2, r));
    sb.push_back(mk(1, 2, 2));
    while (sb.size() > 0) begin
      wait_tick();
      e = sb.pop_front();
      total++;
      if (obs() !== e) begin bad++; $display("FAIL midrst_lead left=%0d got %h want %h", sb.size(), obs(), e); end
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (obs() !== mk(0, 0, 5)) begin bad++; $display("FAIL midrst_state got %h want %h", obs(), mk(0, 0, 5)); end
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL midrst_tick got %b want 0", tick); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (tick !== (k == 3)) begin bad++; $display("FAIL midrst_prescale edge%0d got %b want %b", k, tick, k == 3); end
    end
    sb.push_back(mk(0, 0, 4));
    wait_tick();
    e = sb.pop_front();
    total++;
    if (obs() !== e) begin bad++; $display("FAIL midrst_resume got %h want %h", obs(), e); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_skip_demand();
    test_skip_idle();
    test_preempt();
    test_flash();
    test_reset_midphase();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
